exu_alu_mdu: RTL and testbench
==============================

# exu_alu_mdu

Parametrised execute-stage arithmetic unit that replaces the single-cycle ALU. It covers the base integer ops plus the RV M-extension multiply, divide and remainder ops, with word (W) variants. Operands enter through a valid/ready handshake, and results leave through a registered valid/ready output. Base ops complete in one cycle. Multiply and divide run iteratively. A flush input drops in-flight work on pipeline redirect.

## Interface
Parameters:
- `XLEN`, 64: operand/result width (32 or 64).
- `TAG_W`, 5: width of opaque tag (destination register index) carried from input to output.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous abort of accepted/in-flight op.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `in_op`  in  5  operation code (`exu_pkg::alu_op_e`).
- `in_w`  in  1  word op: use low 32 bits, sign-extend 32-bit result.
- `in_a`, `in_b`  in  XLEN  operands.
- `in_tag`  in  TAG_W  passed to `out_tag`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag of the op.

## Operation
- Ops: ADD SUB SLT SLTU AND OR XOR SLL SRL SRA MUL MULH MULHSU MULHU DIV DIVU REM REMU.
- `in_w` is honoured for ADD SUB SLL SRL SRA MUL DIV DIVU REM REMU and ignored for all others. When `XLEN`=32, `in_w` is ignored.
- Shift amount is `b[5:0]` at XLEN=64 and `b[4:0]` when W or XLEN=32.
- W results are the 32-bit result sign-extended from bit 31. This applies to shifts too.
- Base ops compute combinationally and register into the output on accept.
- Multiply datapath:
  - Operands are converted to magnitudes per signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned treatment with the low half taken.
  - Radix-2 shift-add runs for N iterations (N = 32 for W, else XLEN).
  - The 2N-bit product is negated on completion if the signs differ.
  - MUL returns the low half; MULH* returns the high half.
- Divide datapath:
  - Radix-2 restoring division on magnitudes for N iterations.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Division special cases complete in one cycle without iterating:
  - Divisor 0: quotient is all ones, remainder is the dividend.
  - Signed most-negative ÷ −1: quotient is the dividend, remainder is 0.
  - Both are evaluated at width N.
- FSM:
  - IDLE: accept → DONE (base op or div special case) or BUSY (mul/div, counter ← N−1).
  - BUSY: one iteration per cycle. When the counter reaches 0 → DONE.
  - DONE: `out_valid`=1. If `out_ready`, go to IDLE, or take a new accept in the same cycle and follow the IDLE rules.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). It is combinational and has no dependency on `in_valid`.
- `flush`:
  - The next state is IDLE and any op offered in the same cycle is not accepted.
  - `out_valid` is 0 from the next cycle.
  - Flush takes priority over accept and over a DONE-state handshake.

## Timing
- Accept occurs in the cycle where `in_valid & in_ready & !flush`; call it cycle 0.
- Base op or div special case: `out_valid` high in cycle 1.
- Mul/div: `out_valid` high in cycle N+1 (33 for W, 65 at XLEN=64).
- `out_result` and `out_tag` stay stable while `out_valid & !out_ready`.
- Back-to-back base ops with `out_ready` held high sustain one result per cycle.
- Reset values:
  - state IDLE
  - `out_valid` 0
  - `out_result` 0
  - `out_tag` 0
  - `in_ready` 1 in the first cycle after reset
  - iteration counter 0
- Reset or flush mid-BUSY discards partial product/quotient. No output is produced for that op.

## Structure
- `exu_pkg` holds:
  - `alu_op_e` (5-bit enum, values fixed: ADD=0 … REMU=17)
  - `ALU_OP_W`=5
  - FSM state enum {IDLE, BUSY, DONE}
- Sub-module `exu_mdu_iter` holds the iterative mul/div datapath: operand magnitude conversion, counter, shift registers, final sign fix-up, and done pulse. The top level holds the FSM, the base-op logic and the output registers.

## Test plan
- ADD, XLEN=64, a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result 0, `out_valid` in cycle 1. Then ADD W with a=0x7FFF_FFFF, b=1 → 0xFFFF_FFFF_8000_0000.
- SRA W, a=0x8000_0000, b=4 → 0xFFFF_FFFF_F800_0000. SLTU with a=1, b=−1 → 1. SLT with the same operands → 0.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE with `out_valid` exactly in cycle 65. MUL W, a=−3, b=7 → 0xFFFF_FFFF_FFFF_FFEB in cycle 33.
- DIV a=−7, b=2 → −3. REM with the same operands → −1. DIVU 5/0 → all ones in cycle 1. REM 5/0 → 5.
- DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 in cycle 1. REM with the same operands → 0.
- Backpressure and flush:
  - Hold `out_ready`=0 for 3 cycles after DONE → result and tag unchanged, `in_ready`=0.
  - Flush in BUSY cycle 10 → `out_valid` never asserts for that op, and `in_ready`=1 in the next cycle.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared types for the execute-stage ALU/MDU: operation codes and control states.
package exu_pkg;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLT    = 5'd2,
    OP_SLTU   = 5'd3,
    OP_AND    = 5'd4,
    OP_OR     = 5'd5,
    OP_XOR    = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exu_mdu_iter.sv
// Iterative radix-2 multiply (shift-add) and restoring divide on operand magnitudes,
// with final sign fix-up; result_c is valid in the cycle done_c is high.
module exu_mdu_iter
  import exu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic                w,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                done_c,
  output logic [XLEN-1:0]     result_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned P_W   = 2 * XLEN;

  alu_op_e         op_e;
  logic            sgn_a, sgn_b, neg_a, neg_b, is_div;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  logic             busy_q, is_div_q, is_rem_q, hi_q, w_q, neg_q, neg_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  x_q, x_n;
  logic [P_W-1:0]   y_q, acc_q, acc_n, prod;
  logic [XLEN:0]    sh, diff;
  logic [XLEN-1:0]  quo, rem, raw;

  assign op_e   = alu_op_e'(op);
  assign sgn_a  = op_e inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b  = op_e inside {OP_MULH, OP_DIV, OP_REM};
  assign is_div = op_e inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  // Operands narrowed to the active width, then reduced to magnitudes
  assign a_ext = !w ? a : (sgn_a ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]));
  assign b_ext = !w ? b : (sgn_b ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]));
  assign neg_a = sgn_a & a_ext[XLEN-1];
  assign neg_b = sgn_b & b_ext[XLEN-1];
  assign a_mag = neg_a ? -a_ext : a_ext;
  assign b_mag = neg_b ? -b_ext : b_ext;

  // One iteration: x holds multiplier / dividend-then-quotient, y multiplicand / divisor
  always_comb begin
    sh   = {acc_q[XLEN-1:0], x_q[XLEN-1]};
    diff = sh - {1'b0, y_q[XLEN-1:0]};
    if (is_div_q) begin
      acc_n = P_W'(diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]);
      x_n   = {x_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_n = acc_q + (x_q[0] ? y_q : '0);
      x_n   = x_q >> 1;
    end
  end

  assign prod     = neg_q ? -acc_n : acc_n;
  assign quo      = neg_q ? -x_n : x_n;
  assign rem      = neg_r_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
  assign raw      = is_div_q ? (is_rem_q ? rem : quo)
                             : (hi_q ? prod[P_W-1:XLEN] : prod[XLEN-1:0]);
  assign result_c = w_q ? XLEN'($signed(raw[31:0])) : raw;
  assign done_c   = busy_q & (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= w ? CNT_W'(31) : CNT_W'(XLEN - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Word divides pre-align the dividend so the top N bits feed the first N steps
  always_ff @(posedge clk) begin
    if (start) begin
      is_div_q <= is_div;
      is_rem_q <= op_e inside {OP_REM, OP_REMU};
      hi_q     <= op_e inside {OP_MULH, OP_MULHSU, OP_MULHU};
      w_q      <= w;
      neg_q    <= neg_a ^ neg_b;
      neg_r_q  <= neg_a;
      acc_q    <= '0;
      if (is_div) begin
        x_q <= w ? (a_mag << (XLEN - 32)) : a_mag;
        y_q <= P_W'(b_mag);
      end else begin
        x_q <= b_mag;
        y_q <= P_W'(a_mag);
      end
    end else if (busy_q) begin
      acc_q <= acc_n;
      x_q   <= x_n;
      if (!is_div_q) y_q <= y_q << 1;
    end
  end

endmodule

// File: rtl/exu_alu_mdu.sv
// Execute-stage integer unit: single-cycle base ops, iterative M-extension ops,
// valid/ready in and registered valid/ready out, with pipeline flush.
module exu_alu_mdu
  import exu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic                in_w,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int unsigned SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  alu_op_e         op;
  logic            eff_w, accept, is_mdu, is_div, is_rem, b_zero, ovf, special;
  logic            start, load_out, mdu_done_c;
  logic [31:0]     a_lo, b_lo, sll_w, srl_w, sra_w;
  logic [XLEN-1:0] add_r, sub_r, a_n, base_res, special_res, result_d, mdu_result_c;
  logic [TAG_W-1:0] tag_q, tag_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign op       = alu_op_e'(in_op);
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign eff_w    = in_w & (XLEN == 64) &
                    (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
                                OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  assign is_mdu   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                               OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_rem   = op inside {OP_REM, OP_REMU};

  assign a_lo  = in_a[31:0];
  assign b_lo  = in_b[31:0];
  assign add_r = in_a + in_b;
  assign sub_r = in_a - in_b;
  assign sll_w = a_lo << b_lo[4:0];
  assign srl_w = a_lo >> b_lo[4:0];
  assign sra_w = 32'($signed(a_lo) >>> b_lo[4:0]);

  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:  base_res = eff_w ? sext32(add_r[31:0]) : add_r;
      OP_SUB:  base_res = eff_w ? sext32(sub_r[31:0]) : sub_r;
      OP_SLT:  base_res = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: base_res = XLEN'(in_a < in_b);
      OP_AND:  base_res = in_a & in_b;
      OP_OR:   base_res = in_a | in_b;
      OP_XOR:  base_res = in_a ^ in_b;
      OP_SLL:  base_res = eff_w ? sext32(sll_w) : (in_a << in_b[SH_W-1:0]);
      OP_SRL:  base_res = eff_w ? sext32(srl_w) : (in_a >> in_b[SH_W-1:0]);
      OP_SRA:  base_res = eff_w ? sext32(sra_w) : XLEN'($signed(in_a) >>> in_b[SH_W-1:0]);
      default: base_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow resolve without iterating, judged at the active width
  assign a_n    = eff_w ? sext32(a_lo) : in_a;
  assign b_zero = eff_w ? (b_lo == '0) : (in_b == '0);
  assign ovf    = (op inside {OP_DIV, OP_REM}) &
                  (eff_w ? ((a_lo == 32'h8000_0000) & (b_lo == '1))
                         : ((in_a == MIN_NEG) & (in_b == '1)));
  assign special     = is_div & (b_zero | ovf);
  assign special_res = b_zero ? (is_rem ? a_n : '1) : (is_rem ? '0 : a_n);

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    load_out = 1'b0;
    result_d = base_res;
    tag_d    = in_tag;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE || out_ready) begin
          state_d = IDLE;
          if (accept) begin
            if (is_mdu && !special) begin
              state_d = BUSY;
              start   = 1'b1;
            end else begin
              state_d  = DONE;
              load_out = 1'b1;
              result_d = is_mdu ? special_res : base_res;
            end
          end
        end
      end
      BUSY: begin
        if (mdu_done_c) begin
          state_d  = DONE;
          load_out = 1'b1;
          result_d = mdu_result_c;
          tag_d    = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      start    = 1'b0;
      load_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      tag_q      <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      if (start) tag_q <= in_tag;
      if (load_out) begin
        out_result <= result_d;
        out_tag    <= tag_d;
      end
    end
  end

  exu_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (in_op),
    .w        (eff_w),
    .a        (in_a),
    .b        (in_b),
    .done_c   (mdu_done_c),
    .result_c (mdu_result_c)
  );

endmodule

// File: tb/tb_exu_alu_mdu.sv
// Scoreboard bench for exu_alu_mdu at XLEN=64: results, latencies, backpressure and flush.
module tb_exu_alu_mdu;
  import exu_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_w, out_valid, out_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  exu_alu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_w       (in_w),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq($sformatf("result tag%0d", e.tag), out_result, e.res);
        check_eq("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int lat);
    int   cyc;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_w = w; in_a = a; in_b = b; in_tag = tag;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("accept", 64'(in_ready), 64'd1);
    e.tag = tag;
    e.res = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq($sformatf("latency op%0d", op), 64'(cyc), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_w = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    vecs.push_back('{OP_ADD,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1});
    vecs.push_back('{OP_ADD,    1'b1, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{OP_SRA,    1'b1, 64'h8000_0000, 64'h4, 64'hFFFF_FFFF_F800_0000, 1});
    vecs.push_back('{OP_SLTU,   1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1});
    vecs.push_back('{OP_SLT,    1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1});
    vecs.push_back('{OP_SLT,    1'b1, 64'h8000_0000, 64'h1, 64'h0, 1});
    vecs.push_back('{OP_SUB,    1'b0, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1});
    vecs.push_back('{OP_SUB,    1'b1, 64'h8000_0000, 64'h1, 64'h7FFF_FFFF, 1});
    vecs.push_back('{OP_AND,    1'b0, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'h0F00_0F00, 1});
    vecs.push_back('{OP_OR,     1'b0, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'hFFF0_FFF0, 1});
    vecs.push_back('{OP_SLL,    1'b0, 64'h1, 64'd67, 64'h8, 1});
    vecs.push_back('{OP_SLL,    1'b1, 64'h1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{OP_SRL,    1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1, 64'h4000_0000, 1});
    vecs.push_back('{OP_SRA,    1'b0, 64'h8000_0000_0000_0000, 64'h4, 64'hF800_0000_0000_0000, 1});
    vecs.push_back('{OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{OP_MUL,    1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7, 64'hFFFF_FFFF_FFFF_FFEB, 33});
    vecs.push_back('{OP_MUL,    1'b0, 64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0000, 65});
    vecs.push_back('{OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{OP_DIVU,   1'b0, 64'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{OP_REM,    1'b0, 64'h5, 64'h0, 64'h5, 1});
    vecs.push_back('{OP_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1});
    vecs.push_back('{OP_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1});
    vecs.push_back('{OP_DIVU,   1'b1, 64'd100, 64'd7, 64'd14, 33});
    vecs.push_back('{OP_REMU,   1'b1, 64'd100, 64'd7, 64'd2, 33});
    vecs.push_back('{OP_DIV,    1'b1, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33});
    vecs.push_back('{OP_REM,    1'b1, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{OP_DIV,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{OP_DIVU,   1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", out_result, 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i),
             vecs[i].exp, vecs[i].lat);

    // Back-to-back base ops: one result per cycle
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = OP_ADD; in_w = 1'b0;
      in_a = 64'(i * 100); in_b = 64'd7; in_tag = 5'(20 + i);
      @(negedge clk);
      check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
      e.tag = 5'(20 + i);
      e.res = 64'(i * 100 + 7);
      sb_q.push_back(e);
      if (i > 0) check_eq("b2b_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Backpressure: held result and tag, no new accept
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(OP_XOR, 1'b0, 64'hF0F0, 64'h0FF0, 5'd9, 64'hFF00, 1);
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_result", out_result, 64'hFF00);
      check_eq("bp_tag", 64'(out_tag), 64'd9);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Flush in BUSY cycle 10 drops the multiply
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_MUL; in_w = 1'b0; in_a = 64'd3; in_b = 64'd5; in_tag = 5'd13;
    @(negedge clk);
    check_eq("fl_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("fl_busy_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("fl_in_ready_after", 64'(in_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      repeat (70) begin
        if (out_valid) seen++;
        @(negedge clk);
      end
      check_eq("fl_no_output", 64'(seen), 64'd0);
    end

    run_op(OP_DIVU, 1'b0, 64'd1000, 64'd10, 5'd30, 64'd100, 65);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
